// File: rtl/axi4lite_req_arbiter.sv
// Round-robin arbiter that shares one axi4lite_master command port among NUM_REQ requesters.
// One command is in flight at a time; it completes on m_done or after TIMEOUT wait cycles.
module axi4lite_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           rst_N,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [DATAWIDTH-1:0]           resp_rdata,
    output logic                           resp_err,
    output logic                           m_rd_en,
    output logic                           m_wr_en,
    output logic [ADDRWIDTH-1:0]           m_rd_addr,
    output logic [ADDRWIDTH-1:0]           m_wr_addr,
    output logic [DATAWIDTH-1:0]           m_wdata,
    input  logic                           m_done,
    input  logic [DATAWIDTH-1:0]           m_rdata,
    output logic                           busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [PTR_W-1:0]       owner_r;
    logic [PTR_W-1:0]       grant_idx_s;
    logic [PTR_W-1:0]       owner_next_s;
    logic                   grant_vld_s;
    logic                   write_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   cnt_limit_s;
    logic                   resp_hs_s;
    logic [ADDRWIDTH-1:0]   addr_sel_s;
    logic [DATAWIDTH-1:0]   wdata_sel_s;
    logic [NUM_REQ-1:0]     owner_onehot_s;

    logic                   m_rd_en_r;
    logic                   m_wr_en_r;
    logic [ADDRWIDTH-1:0]   m_rd_addr_r;
    logic [ADDRWIDTH-1:0]   m_wr_addr_r;
    logic [DATAWIDTH-1:0]   m_wdata_r;
    logic [NUM_REQ-1:0]     resp_valid_r;
    logic [DATAWIDTH-1:0]   resp_rdata_r;
    logic                   resp_err_r;
    logic                   busy_r;

    // Rotating priority search: walking offsets downward lets the smallest offset from rr_ptr win.
    always_comb begin
        int idx_v;
        idx_v       = 0;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_v       = int'(rr_ptr_r) + i;
            idx_v       = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
            grant_idx_s = req_valid[idx_v] ? PTR_W'(idx_v) : grant_idx_s;
            grant_vld_s = grant_vld_s | req_valid[idx_v];
        end
    end

    assign addr_sel_s     = req_addr[grant_idx_s*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_sel_s    = req_wdata[grant_idx_s*DATAWIDTH +: DATAWIDTH];
    assign cnt_limit_s    = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign resp_hs_s      = (state_r == ST_RESP) && resp_ready[owner_r];
    assign owner_next_s   = (owner_r == PTR_W'(NUM_REQ - 1)) ? '0 : (owner_r + PTR_W'(1));
    assign owner_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;

    // Accept pulse: the only combinational output, forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_r == ST_IDLE) && grant_vld_s && rst_N) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state decode; m_done only matters while waiting.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = grant_vld_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT:  state_next_s = (m_done || cnt_limit_s) ? ST_RESP : ST_WAIT;
            ST_RESP:  state_next_s = resp_hs_s ? ST_IDLE : ST_RESP;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch, wait counter, response capture and registered outputs.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            rr_ptr_r     <= '0;
            owner_r      <= '0;
            write_r      <= 1'b0;
            cnt_r        <= '0;
            m_rd_en_r    <= 1'b0;
            m_wr_en_r    <= 1'b0;
            m_rd_addr_r  <= '0;
            m_wr_addr_r  <= '0;
            m_wdata_r    <= '0;
            resp_valid_r <= '0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        owner_r     <= grant_idx_s;
                        write_r     <= req_write[grant_idx_s];
                        m_rd_en_r   <= ~req_write[grant_idx_s];
                        m_wr_en_r   <= req_write[grant_idx_s];
                        m_rd_addr_r <= req_write[grant_idx_s] ? '0 : addr_sel_s;
                        m_wr_addr_r <= req_write[grant_idx_s] ? addr_sel_s : '0;
                        m_wdata_r   <= wdata_sel_s;
                        busy_r      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    m_rd_en_r <= 1'b0;
                    m_wr_en_r <= 1'b0;
                    cnt_r     <= '0;
                end
                ST_WAIT: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (m_done) begin
                        resp_valid_r <= owner_onehot_s;
                        resp_rdata_r <= write_r ? '0 : m_rdata;
                        resp_err_r   <= 1'b0;
                    end else if (cnt_limit_s) begin
                        resp_valid_r <= owner_onehot_s;
                        resp_rdata_r <= '0;
                        resp_err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_hs_s) begin
                        rr_ptr_r     <= owner_next_s;
                        resp_valid_r <= '0;
                        resp_rdata_r <= '0;
                        resp_err_r   <= 1'b0;
                        m_rd_addr_r  <= '0;
                        m_wr_addr_r  <= '0;
                        m_wdata_r    <= '0;
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign m_rd_en    = m_rd_en_r;
    assign m_wr_en    = m_wr_en_r;
    assign m_rd_addr  = m_rd_addr_r;
    assign m_wr_addr  = m_wr_addr_r;
    assign m_wdata    = m_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Bench for axi4lite_req_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model (owner, age since accept, resolved response).
module tb_axi4lite_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_N;
    logic [N-1:0]    req_valid, req_write, req_ready, resp_valid, resp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_rdata, m_wdata, m_rdata;
    logic [AW-1:0]   m_rd_addr, m_wr_addr;
    logic            resp_err, m_rd_en, m_wr_en, m_done, busy;

    int checks = 0;
    int fails  = 0;

    // transaction-level model state
    bit            mo_busy, mo_resolved, mo_wr, mo_err;
    int            mo_owner, mo_age, mo_rr;
    logic [AW-1:0] mo_addr;
    logic [DW-1:0] mo_wdata, mo_rdata;

    logic [N-1:0] exp_order [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] got;

    axi4lite_req_arbiter #(.NUM_REQ(N), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_N(rst_N),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_rd_addr(m_rd_addr), .m_wr_addr(m_wr_addr),
        .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mo_busy = 0; mo_resolved = 0; mo_wr = 0; mo_err = 0;
        mo_owner = 0; mo_age = 0; mo_rr = 0;
        mo_addr = '0; mo_wdata = '0; mo_rdata = '0;
    endtask

    // first valid requester scanning rr, rr+1, ... modulo N; -1 if none
    function automatic int pick();
        int r = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(mo_rr + k) % N]) r = (mo_rr + k) % N;
        end
        return r;
    endfunction

    task automatic compare_model();
        logic [N-1:0]  e_ready = '0, e_rv = '0;
        logic [AW-1:0] e_ra = '0, e_wa = '0;
        logic [DW-1:0] e_wd = '0, e_rd = '0;
        logic          e_ren = 0, e_wen = 0, e_err = 0, e_busy = 0;
        int g;
        if (rst_N) begin
            if (!mo_busy) begin
                g = pick();
                if (g >= 0) e_ready[g] = 1'b1;
            end else begin
                e_busy = 1'b1;
                e_wd   = mo_wdata;
                if (mo_wr) e_wa = mo_addr; else e_ra = mo_addr;
                if (mo_age == 1) begin e_ren = !mo_wr; e_wen = mo_wr; end
                if (mo_resolved) begin
                    e_rv[mo_owner] = 1'b1; e_rd = mo_rdata; e_err = mo_err;
                end
            end
        end
        chk("req_ready", req_ready, e_ready);
        chk("resp_valid", resp_valid, e_rv);
        chk("resp_rdata", resp_rdata, e_rd);
        chk("resp_err", resp_err, e_err);
        chk("m_rd_en", m_rd_en, e_ren);
        chk("m_wr_en", m_wr_en, e_wen);
        chk("m_rd_addr", m_rd_addr, e_ra);
        chk("m_wr_addr", m_wr_addr, e_wa);
        chk("m_wdata", m_wdata, e_wd);
        chk("busy", busy, e_busy);
    endtask

    task automatic advance_model();
        int g;
        if (!rst_N) begin
            model_reset();
        end else if (!mo_busy) begin
            g = pick();
            if (g >= 0) begin
                mo_busy = 1; mo_resolved = 0; mo_owner = g; mo_age = 1;
                mo_wr = req_write[g]; mo_addr = req_addr[g*AW +: AW]; mo_wdata = req_wdata[g*DW +: DW];
            end
        end else if (mo_resolved) begin
            if (resp_ready[mo_owner]) begin
                mo_busy = 0; mo_resolved = 0; mo_rr = (mo_owner + 1) % N;
            end
        end else begin
            // waiting window: TO cycles starting two cycles after accept
            if (mo_age >= 2) begin
                if (m_done) begin
                    mo_resolved = 1; mo_err = 0; mo_rdata = mo_wr ? '0 : m_rdata;
                end else if (mo_age - 2 == TO - 1) begin
                    mo_resolved = 1; mo_err = 1; mo_rdata = '0;
                end
            end
            mo_age++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_txn();
        step();
        m_done = 1'b1; m_rdata = $urandom;
        step();
        m_done = 1'b0; resp_ready = '1;
        step();
        resp_ready = '0;
    endtask

    task automatic auto_txn(input logic [N-1:0] vmask, output logic [N-1:0] g);
        req_valid = vmask; req_write = 4'($urandom);
        req_addr  = {$urandom, $urandom, $urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        #1 g = req_ready;
        step();
        finish_txn();
    endtask

    initial begin
        rst_N = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        resp_ready = '0; m_done = 1'b0; m_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset resp_valid", resp_valid, 4'b0000);
        chk("reset m_rd_en", m_rd_en, 1'b0);
        rst_N = 1'b1;
        step();

        // round robin: all valid, then wrap from rr=3 with only 0 and 2 valid
        for (int i = 0; i < 7; i++) begin
            auto_txn(4'b1111, got);
            if (i < 5) chk("rr order", got, exp_order[i]);
        end
        auto_txn(4'b0101, got); chk("rr wrap first", got, 4'b0001);
        auto_txn(4'b0101, got); chk("rr wrap second", got, 4'b0100);

        // single read, minimum latency
        req_valid = 4'b0001; req_write = '0; req_addr[0 +: AW] = 32'h0000_0010;
        #1 chk("read accept", req_ready, 4'b0001);
        step(); req_valid = '0;
        chk("read m_rd_en", m_rd_en, 1'b1);
        chk("read m_wr_en", m_wr_en, 1'b0);
        chk("read m_rd_addr", m_rd_addr, 32'h0000_0010);
        step();
        m_done = 1'b1; m_rdata = 32'hCAFE_F00D;
        step(); m_done = 1'b0;
        chk("read resp_valid", resp_valid, 4'b0001);
        chk("read rdata", resp_rdata, 32'hCAFE_F00D);
        chk("read err", resp_err, 1'b0);
        resp_ready = 4'b0001; step(); resp_ready = '0;
        chk("read done busy", busy, 1'b0);

        // write from requester 2
        req_valid = 4'b0100; req_write = 4'b0100;
        req_addr[2*AW +: AW] = 32'h0000_0024; req_wdata[2*DW +: DW] = 32'h1234_5678;
        step(); req_valid = '0;
        chk("write m_wr_en", m_wr_en, 1'b1);
        chk("write m_rd_en", m_rd_en, 1'b0);
        chk("write m_wr_addr", m_wr_addr, 32'h0000_0024);
        chk("write m_wdata", m_wdata, 32'h1234_5678);
        step();
        m_done = 1'b1; m_rdata = 32'hFFFF_FFFF;
        step(); m_done = 1'b0;
        chk("write resp_valid", resp_valid, 4'b0100);
        chk("write rdata", resp_rdata, 32'h0000_0000);
        resp_ready = 4'b0100; step(); resp_ready = '0;

        // timeout with no completion, then completion on the last wait cycle
        for (int pass = 0; pass < 2; pass++) begin
            req_valid = 4'b0010; req_write = '0;
            step(); req_valid = '0;
            step();
            for (int i = 0; i < TO - 1; i++) step();
            chk("timeout early", resp_valid, 4'b0000);
            if (pass == 1) begin m_done = 1'b1; m_rdata = 32'h0BAD_F00D; end
            step(); m_done = 1'b0;
            chk("timeout resp_valid", resp_valid, 4'b0010);
            chk("timeout err", resp_err, (pass == 0) ? 1'b1 : 1'b0);
            chk("timeout rdata", resp_rdata, (pass == 0) ? 32'h0 : 32'h0BAD_F00D);
            resp_ready = 4'b0010; step(); resp_ready = '0;
        end

        // response backpressure from requester 3
        req_valid = 4'b1000; req_write = 4'b1000;
        step(); step();
        m_done = 1'b1; step(); m_done = 1'b0;
        req_valid = 4'b1111; resp_ready = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp resp_valid", resp_valid, 4'b1000);
            chk("bp busy", busy, 1'b1);
            chk("bp req_ready", req_ready, 4'b0000);
        end
        resp_ready = 4'b1000; step(); resp_ready = '0;
        #1 chk("bp next grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        finish_txn();

        // asynchronous reset in the middle of a wait
        req_valid = 4'b0010; req_write = '0; req_addr[AW +: AW] = 32'h0000_0040;
        step(); req_valid = '0;
        step(); step();
        req_valid = 4'b1111;
        #2 rst_N = 1'b0;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst m_rd_addr", m_rd_addr, 32'h0);
        chk("rst req_ready", req_ready, 4'b0000);
        chk("rst resp_valid", resp_valid, 4'b0000);
        model_reset();
        m_done = 1'b1;
        @(posedge clk); #1 rst_N = 1'b1;
        #1 chk("rst winner", req_ready, 4'b0001);
        step(); req_valid = '0;
        step(); m_done = 1'b0;
        step(); step();
        m_done = 1'b1; m_rdata = 32'h5A5A_A5A5;
        step(); m_done = 1'b0;
        chk("rst resp", resp_valid, 4'b0001);
        resp_ready = 4'b0001; step(); resp_ready = '0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid  = 4'($urandom);
            req_write  = 4'($urandom);
            req_addr   = {$urandom, $urandom, $urandom, $urandom};
            req_wdata  = {$urandom, $urandom, $urandom, $urandom};
            m_done     = ($urandom_range(0, 3) == 0);
            m_rdata    = $urandom;
            resp_ready = 4'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi4lite_req_arbiter.md
Name: axi4lite_req_arbiter

Overview:
Round-robin arbiter/sequencer that shares the single axi4lite_master command port (rd_en, wr_en, Read_Address, Write_Address, Write_Data) among NUM_REQ independent requesters. It accepts one request at a time and issues it to the master as a one-cycle enable pulse. It then waits for the master's completion or a timeout and returns the read data and status to the owning requester. It sits above the master inside DUV, replacing direct testbench drive of the master command inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDRWIDTH, 32, address width (matches axi4lite_pkg)
DATAWIDTH, 32, data width (matches axi4lite_pkg)
TIMEOUT, 255, max cycles in WAIT before error completion (1..65535)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_N  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  request pending, one bit per requester
req_write  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*ADDRWIDTH  packed addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
req_wdata  input  NUM_REQ*DATAWIDTH  packed write data, same packing
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse
resp_valid  output  NUM_REQ  one-hot response valid
resp_ready  input  NUM_REQ  requester accepts response
resp_rdata  output  DATAWIDTH  read data (0 for writes/errors)
resp_err  output  1  1=timeout
m_rd_en  output  1  to master rd_en
m_wr_en  output  1  to master wr_en
m_rd_addr  output  ADDRWIDTH  to master Read_Address
m_wr_addr  output  ADDRWIDTH  to master Write_Address
m_wdata  output  DATAWIDTH  to master Write_Data
m_done  input  1  master transaction complete pulse
m_rdata  input  DATAWIDTH  master read data, valid with m_done
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_N=0): state=IDLE, rr_ptr=0, all outputs 0, wait counter 0. Outputs drop immediately; an in-flight transaction is abandoned with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...). Same cycle: req_ready[g]=1 for one cycle; latch g, req_write[g], the address and the wdata into internal registers. Next state ISSUE. With no req_valid, stay in IDLE.
- ISSUE (exactly 1 cycle): m_wr_en=1 if the latched command is a write, else m_rd_en=1; never both. The addresses and m_wdata come from the latched registers and are held stable from ISSUE until the return to IDLE. The unused address output is 0. Clear the counter. Next state WAIT.
- WAIT: enables low. m_done is sampled only in WAIT; m_done in any other state is ignored.
  - m_done=1: capture m_rdata (reads) or 0 (writes); err=0; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without m_done: rdata=0, err=1, go to RESP.
  - m_done on the timeout cycle: m_done wins (err=0).
- RESP: resp_valid[g]=1, with resp_rdata and resp_err stable. Hold until resp_ready[g]=1. On that cycle: rr_ptr=(g+1) mod NUM_REQ, next state IDLE. resp_valid drops the next cycle.
- Minimum latency: accept cycle 0, enable cycle 1, m_done cycle 2, resp_valid cycle 3.
- Back-to-back: a new grant may occur the cycle after the return to IDLE.
- A requester deasserting req_valid while not granted is legal. After its req_ready pulse, the granted request's inputs are ignored.
- resp_ready on non-granted bits is ignored.
- All latched registers are sized exactly per the parameters. rr_ptr is $clog2(NUM_REQ) bits with explicit wrap; it is never derived from natural overflow.

Test Plan:
1. Single read: req_valid=0001, write=0, addr0=0x10; m_done at cycle 2 with m_rdata=0xCAFEF00D -> m_rd_en pulse cycle 1, m_rd_addr=0x10; resp_valid=0001 cycle 3, rdata=0xCAFEF00D, err=0.
2. Round-robin: all four valid continuously, m_done 1 cycle after each enable, resp_ready=1 -> grant order 0,1,2,3,0. rr_ptr=3 grant wraps to 0 when only bits 0 and 2 valid after bit 3 -> order 0, then 2.
3. Write: requester 2 writes addr=0x24, data=0x12345678 -> m_wr_en one cycle, m_wr_addr=0x24, m_wdata=0x12345678, m_rd_en=0; response rdata=0, err=0.
4. Timeout: TIMEOUT=8, no m_done -> resp_valid 8 cycles after WAIT entry, err=1, rdata=0; m_done on exactly that cycle -> err=0.
5. Response backpressure: resp_ready=0 for 5 cycles -> resp_valid, rdata and err held, busy=1, no new grant; grant follows the cycle after the resp_ready handshake.
6. Reset mid-WAIT: rst_N low asynchronously -> outputs 0 the same cycle; after release, state=IDLE and rr_ptr=0 so requester 0 wins; a stale m_done is ignored.
